instr_stream_loader: RTL and testbench
======================================

Name: instr_stream_loader

Overview:
Boot-time program loader and the encoding end of the instruction format.
- Accepts decoded instruction fields (opcode, rd, rb, ra) on a valid/ready stream.
- Packs them into the 32-bit instruction word defined by the processor's instruction format.
- Writes each word to the instruction memory write port at consecutive word addresses, with wait-state support.
- Sits between the test/boot source and imem. Its output is exactly what the fetch/decode path consumes.

Parameters:
BASE_ADDR, 0, byte address of the first word written in a session; must be 4-aligned.
MEM_SIZE, 4096 (package MEM_SIZE), memory size in bytes; highest legal word address is MEM_SIZE-4.

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  begin load session; sampled only in IDLE
s_valid  input  1  field bundle valid
s_ready  output  1  loader can accept bundle
s_opcode  input  OPCODE_WIDTH (4)  opcode field
s_rd  input  REGISTER_WIDTH (5)  destination register
s_rb  input  REGISTER_WIDTH (5)  source register b
s_ra  input  REGISTER_WIDTH (5)  source register a
s_last  input  1  final bundle of session
mem_we  output  1  write request to imem
mem_addr  output  ADDR_WIDTH (32)  byte address
mem_wdata  output  INSTR_WIDTH (32)  packed instruction
mem_ack  input  1  imem accepted write this cycle
busy  output  1  session in progress
done  output  1  one-cycle pulse at session end
err_illegal  output  1  sticky: opcode > JMP seen
err_overflow  output  1  sticky: write beyond MEM_SIZE-4 attempted
count  output  32  words written this session

Behaviour:
Clock and reset:
- Single clock clk. rst is asynchronous and active-high.
- Reset values: s_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err_illegal=0, err_overflow=0, count=0. FSM goes to IDLE.
- Reset mid-operation abandons any pending write. No partial state survives.

Packing (combinational from latched fields):
- bits[3:0]=opcode, [8:4]=rd, [13:9]=rb, [18:14]=ra, [31:19]=0.
- Free bits are always zero.

FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - start=1 clears count, err_illegal and err_overflow, and loads mem_addr=BASE_ADDR. Next state ACCEPT.
  - s_ready=0 and busy=0 in this state.
- ACCEPT:
  - s_ready=1, busy=1. A bundle transfers on s_valid&&s_ready.
  - Illegal opcode (4'hE or 4'hF): set err_illegal and discard the bundle. No write, count unchanged.
  - Else if mem_addr > MEM_SIZE-4: set err_overflow and discard the bundle.
  - Else latch the packed word and s_last. Next state WRITE.
  - A discarded bundle with s_last=1 goes to DONE; otherwise the FSM stays in ACCEPT.
- WRITE:
  - mem_we=1, s_ready=0. mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_ack: mem_addr+=4, count+=1. If the latched last flag is set, go to DONE; else go to ACCEPT.
  - Wait states are unbounded.
- DONE:
  - done=1 for exactly one cycle, busy=0. Next state IDLE.
  - mem_addr retains its final value until the next start.

Timing and handshake:
- Latency: handshake at cycle N gives mem_we=1 at N+1. With a zero-wait ack, the next s_ready is at N+2, so peak throughput is 1 word per 2 cycles.
- start outside IDLE is ignored.
- mem_ack outside WRITE is ignored.
- s_valid in IDLE is not consumed.
- Address arithmetic is 32-bit with no wrap; the overflow check runs before every write.

Decomposition:
- Add to params_pkg:
  - function pack_instr(opcode, rd, rb, ra) returning instruction_t with free=0.
  - function is_legal_opcode(logic[3:0]) returning true for values up to JMP.
  - loader FSM state enum typedef.
- One natural sub-module is not required. Packing is a package function. Everything else stays in instr_stream_loader.

Test Plan:
1. start, then one bundle ADD rd=3 rb=1 ra=2 last=1, mem_ack tied 1.
   -> mem_we one cycle, mem_addr=0x0, mem_wdata=0x00008230, done pulse, count=1.
2. Two bundles: JMP rd=rb=ra=31, then SUB rd=0 rb=0 ra=0 last=1.
   -> writes 0x0007FFFD @0x0 and 0x00000003 @0x4, count=2.
3. Bundle with opcode 4'hE, then ADD rd=1 last=1.
   -> no write for the first bundle, err_illegal=1, single write 0x00000010 @0x0, count=1.
4. BASE_ADDR=4092, two legal bundles (second last=1).
   -> first written @0xFFC, second discarded, err_overflow=1, count=1, done pulses.
5. mem_ack held low 3 cycles during WRITE.
   -> mem_we, mem_addr and mem_wdata stable for all 4 cycles, s_ready=0, count increments only on the ack cycle.
6. Assert rst while mem_we=1, then start again.
   -> all outputs at reset values immediately, new session begins at BASE_ADDR, no stale write issued.

Source files
------------

// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared instruction-format widths, types and helpers
package params_pkg;

    localparam int OPCODE_WIDTH   = 4;
    localparam int REGISTER_WIDTH = 5;
    localparam int ADDR_WIDTH     = 32;
    localparam int INSTR_WIDTH    = 32;
    localparam int unsigned MEM_SIZE = 4096;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD  = 4'h0,
        OP_ADDC = 4'h1,
        OP_AND  = 4'h2,
        OP_SUB  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_LDI  = 4'hA,
        OP_BEQ  = 4'hB,
        OP_BNE  = 4'hC,
        OP_JMP  = 4'hD
    } opcode_t;

    // Instruction word layout, MSB first; free bits are always zero.
    typedef struct packed {
        logic [12:0]               free;
        logic [REGISTER_WIDTH-1:0] ra;
        logic [REGISTER_WIDTH-1:0] rb;
        logic [REGISTER_WIDTH-1:0] rd;
        logic [OPCODE_WIDTH-1:0]   opcode;
    } instruction_t;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_ACCEPT = 2'd1,
        LD_WRITE  = 2'd2,
        LD_DONE   = 2'd3
    } loader_state_t;

    function automatic instruction_t pack_instr(
        input logic [OPCODE_WIDTH-1:0]   opcode,
        input logic [REGISTER_WIDTH-1:0] rd,
        input logic [REGISTER_WIDTH-1:0] rb,
        input logic [REGISTER_WIDTH-1:0] ra
    );
        instruction_t w;
        w        = '0;
        w.opcode = opcode;
        w.rd     = rd;
        w.rb     = rb;
        w.ra     = ra;
        return w;
    endfunction

    function automatic logic is_legal_opcode(input logic [OPCODE_WIDTH-1:0] op);
        return op <= OP_JMP;
    endfunction

endpackage

// File: rtl/instr_stream_loader.sv
// rtl/instr_stream_loader.sv - packs instruction fields and writes them to imem
module instr_stream_loader
    import params_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned           MEM_SIZE  = params_pkg::MEM_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [OPCODE_WIDTH-1:0]   s_opcode,
    input  logic [REGISTER_WIDTH-1:0] s_rd,
    input  logic [REGISTER_WIDTH-1:0] s_rb,
    input  logic [REGISTER_WIDTH-1:0] s_ra,
    input  logic                      s_last,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [INSTR_WIDTH-1:0]    mem_wdata,
    input  logic                      mem_ack,
    output logic                      busy,
    output logic                      done,
    output logic                      err_illegal,
    output logic                      err_overflow,
    output logic [31:0]               count
);

    localparam logic [1:0] S_IDLE   = LD_IDLE;
    localparam logic [1:0] S_ACCEPT = LD_ACCEPT;
    localparam logic [1:0] S_WRITE  = LD_WRITE;
    localparam logic [1:0] S_DONE   = LD_DONE;

    // Highest byte address that may still receive a word.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 4);

    logic [1:0] state;
    logic       last_q;

    // Handshake and status outputs are pure decodes of the state so they
    // take their idle values the instant reset asserts.
    always_comb begin
        s_ready = (state == S_ACCEPT);
        mem_we  = (state == S_WRITE);
        busy    = (state == S_ACCEPT) || (state == S_WRITE);
        done    = (state == S_DONE);
    end

    // Session sequencing: accept a bundle, screen it, then hold the write until acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            last_q       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            count        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count        <= '0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                        mem_addr     <= BASE_ADDR;
                        state        <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (s_valid) begin
                        if (!is_legal_opcode(s_opcode)) begin
                            // Bundle is dropped; a dropped last bundle still ends the session.
                            err_illegal <= 1'b1;
                            if (s_last) state <= S_DONE;
                        end else if (mem_addr > LAST_ADDR) begin
                            err_overflow <= 1'b1;
                            if (s_last) state <= S_DONE;
                        end else begin
                            mem_wdata <= pack_instr(s_opcode, s_rd, s_rb, s_ra);
                            last_q    <= s_last;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // Address and data stay frozen through any number of wait states.
                    if (mem_ack) begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(4);
                        count    <= count + 32'd1;
                        state    <= last_q ? S_DONE : S_ACCEPT;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb/tb_instr_stream_loader.sv - directed self-checking bench for instr_stream_loader
module tb_instr_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [3:0]  s_opcode;
    logic [4:0]  s_rd, s_rb, s_ra;
    logic        s_last;
    logic        mem_ack;

    logic        s_ready, mem_we, busy, done, err_illegal, err_overflow;
    logic [31:0] mem_addr, mem_wdata, count;

    logic        s_ready1, mem_we1, busy1, done1, err_illegal1, err_overflow1;
    logic [31:0] mem_addr1, mem_wdata1, count1;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
    int          we_cycles0;

    always #5 clk = ~clk;

    instr_stream_loader #(.BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_opcode(s_opcode), .s_rd(s_rd), .s_rb(s_rb), .s_ra(s_ra), .s_last(s_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow),
        .count(count)
    );

    instr_stream_loader #(.BASE_ADDR(32'd4092)) dut_top (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready1),
        .s_opcode(s_opcode), .s_rd(s_rd), .s_rb(s_rb), .s_ra(s_ra), .s_last(s_last),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_ack(mem_ack),
        .busy(busy1), .done(done1), .err_illegal(err_illegal1), .err_overflow(err_overflow1),
        .count(count1)
    );

    // Log accepted writes away from the active edge.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ack) begin
            wa0.push_back(mem_addr);
            wd0.push_back(mem_wdata);
        end
        if (!rst && mem_we1 && mem_ack) begin
            wa1.push_back(mem_addr1);
            wd1.push_back(mem_wdata1);
        end
        if (!rst && mem_we) we_cycles0++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        we_cycles0 = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input bit use1, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rb, input logic [4:0] ra, input logic last);
        logic got;
        s_opcode = op; s_rd = rd; s_rb = rb; s_ra = ra; s_last = last;
        s_valid  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = use1 ? s_ready1 : s_ready;
        end
        if (!got) chk("send_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input bit use1);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = use1 ? done1 : done;
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_opcode = '0;
        s_rd = '0; s_rb = '0; s_ra = '0; s_last = 1'b0; mem_ack = 1'b1;
        clear_logs();
        @(posedge clk); #1;

        // Reset state
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_addr_top", mem_addr1, 32'd4092);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_errs", {30'd0, err_illegal, err_overflow}, 32'd0);
        chk("rst_count", count, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single ADD rd=3 rb=1 ra=2
        clear_logs();
        chk("t1_idle_not_ready", 32'(s_ready), 32'd0);
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        send(0, 4'h0, 5'd3, 5'd1, 5'd2, 1'b1);
        chk("t1_we_after_hs", 32'(mem_we), 32'd1);
        wait_done(0);
        chk("t1_nwrites", 32'(wa0.size()), 32'd1);
        if (wa0.size() > 0) begin
            chk("t1_addr", wa0[0], 32'h0);
            chk("t1_data", wd0[0], 32'h0000_8230);
        end
        chk("t1_we_cycles", 32'(we_cycles0), 32'd1);
        chk("t1_count", count, 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // 2: JMP all-31 then SUB zeros
        clear_logs();
        pulse_start();
        chk("t2_count_cleared", count, 32'd0);
        send(0, 4'hD, 5'd31, 5'd31, 5'd31, 1'b0);
        send(0, 4'h3, 5'd0, 5'd0, 5'd0, 1'b1);
        wait_done(0);
        chk("t2_nwrites", 32'(wa0.size()), 32'd2);
        if (wa0.size() > 1) begin
            chk("t2_addr0", wa0[0], 32'h0);
            chk("t2_data0", wd0[0], 32'h0007_FFFD);
            chk("t2_addr1", wa0[1], 32'h4);
            chk("t2_data1", wd0[1], 32'h0000_0003);
        end
        chk("t2_count", count, 32'd2);
        chk("t2_final_addr", mem_addr, 32'h8);

        // 3: illegal opcode dropped, then ADD rd=1
        clear_logs();
        pulse_start();
        send(0, 4'hE, 5'd7, 5'd7, 5'd7, 1'b0);
        chk("t3_err_illegal", 32'(err_illegal), 32'd1);
        chk("t3_still_accept", 32'(s_ready), 32'd1);
        chk("t3_no_we", 32'(mem_we), 32'd0);
        send(0, 4'h0, 5'd1, 5'd0, 5'd0, 1'b1);
        wait_done(0);
        chk("t3_nwrites", 32'(wa0.size()), 32'd1);
        if (wa0.size() > 0) begin
            chk("t3_addr", wa0[0], 32'h0);
            chk("t3_data", wd0[0], 32'h0000_0010);
        end
        chk("t3_count", count, 32'd1);
        chk("t3_err_sticky", 32'(err_illegal), 32'd1);

        // 4: BASE_ADDR=4092 overflow on second word
        clear_logs();
        pulse_start();
        chk("t4_err_cleared", 32'(err_illegal1), 32'd0);
        send(1, 4'h0, 5'd2, 5'd0, 5'd0, 1'b0);
        send(1, 4'h3, 5'd4, 5'd0, 5'd0, 1'b1);
        wait_done(1);
        chk("t4_nwrites", 32'(wa1.size()), 32'd1);
        if (wa1.size() > 0) begin
            chk("t4_addr", wa1[0], 32'h0000_0FFC);
            chk("t4_data", wd1[0], 32'h0000_0020);
        end
        chk("t4_err_overflow", 32'(err_overflow1), 32'd1);
        chk("t4_count", count1, 32'd1);
        repeat (4) @(posedge clk);
        #1;

        // 5: three wait states during WRITE
        clear_logs();
        mem_ack = 1'b0;
        pulse_start();
        send(0, 4'h0, 5'd2, 5'd0, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ack = 1'b1;
            chk("t5_we", 32'(mem_we), 32'd1);
            chk("t5_addr", mem_addr, 32'h0);
            chk("t5_data", mem_wdata, 32'h0000_0020);
            chk("t5_s_ready", 32'(s_ready), 32'd0);
            chk("t5_count_hold", count, 32'd0);
            @(posedge clk); #1;
        end
        chk("t5_count", count, 32'd1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_nwrites", 32'(wa0.size()), 32'd1);
        @(posedge clk); #1;
        chk("t5_done_one_cycle", 32'(done), 32'd0);

        // 6: reset while a write is pending
        clear_logs();
        mem_ack = 1'b0;
        pulse_start();
        send(0, 4'h0, 5'd5, 5'd0, 5'd0, 1'b1);
        chk("t6_pending_we", 32'(mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_we", 32'(mem_we), 32'd0);
        chk("t6_rst_addr", mem_addr, 32'h0);
        chk("t6_rst_wdata", mem_wdata, 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_count", count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_stale", 32'(wa0.size()), 32'd0);
        pulse_start();
        send(0, 4'h3, 5'd0, 5'd0, 5'd0, 1'b1);
        wait_done(0);
        chk("t6_nwrites", 32'(wa0.size()), 32'd1);
        if (wa0.size() > 0) begin
            chk("t6_addr", wa0[0], 32'h0);
            chk("t6_data", wd0[0], 32'h0000_0003);
        end
        chk("t6_count", count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
